// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_ctrl
// Purpose  : Auto-baud calibration on a 0x55 sync character plus a small
//            receive FIFO that drops receiver bytes while calibrating.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl #(
  parameter logic [15:0] DEFAULT_DIVIDER = 16'd433,
  parameter logic [15:0] MIN_BIT         = 16'd8,
  parameter int          FIFO_DEPTH      = 4
) (
  input  logic                          uart_clk,
  input  logic                          uart_rst_n,
  input  logic                          uart_ser_rx,
  input  logic                          cal_start,
  output logic [15:0]                   uart_divider,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  output logic                          rx_ready,
  output logic [7:0]                    fifo_data,
  output logic                          fifo_valid,
  input  logic                          fifo_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          cal_busy,
  output logic                          cal_done,
  output logic                          cal_err
);

  localparam int               c_AW    = $clog2(FIFO_DEPTH);
  localparam logic [c_AW:0]    c_DEPTH = (c_AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    WAIT_EDGE = 2'd1,
    MEASURE   = 2'd2,
    QUIET     = 2'd3
  } state_t;

  state_t        r_state;
  logic          r_sync1;
  logic          r_sync2;
  logic          r_prev;
  logic [15:0]   r_meas;
  logic [19:0]   r_quiet;
  logic [15:0]   r_divider;
  logic          r_cal_done;
  logic          r_cal_err;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [c_AW:0] r_wr;
  logic [c_AW:0] r_rd;

  logic          w_fall;
  logic          w_rise;
  logic [20:0]   w_prod;
  logic [19:0]   w_quiet_target;
  logic [19:0]   w_quiet_next;
  logic [c_AW:0] w_count;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;

  assign w_fall = r_prev & ~r_sync2;
  assign w_rise = ~r_prev & r_sync2;

  // Quiet window is 12 bit times; product carried at 21 bits then clamped.
  assign w_prod         = ({5'd0, r_divider} + 21'd1) * 21'd12;
  assign w_quiet_target = w_prod[20] ? 20'hFFFFF : w_prod[19:0];
  assign w_quiet_next   = r_quiet + 20'd1;

  assign w_count = r_wr - r_rd;
  assign w_full  = (w_count == c_DEPTH);
  assign w_empty = (r_wr == r_rd);
  assign w_push  = rx_valid & ~w_full & (r_state == RUN);
  assign w_pop   = ~w_empty & fifo_ready;

  // Outside RUN every byte is swallowed so calibration garbage never queues.
  assign rx_ready     = (r_state != RUN) | ~w_full;
  assign fifo_valid   = ~w_empty;
  assign fifo_data    = r_mem[r_rd[c_AW-1:0]];
  assign fifo_count   = w_count;
  assign uart_divider = r_divider;
  assign cal_busy     = (r_state != RUN);
  assign cal_done     = r_cal_done;
  assign cal_err      = r_cal_err;

  always_ff @(posedge uart_clk or negedge uart_rst_n) begin
    if (!uart_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= uart_ser_rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  always_ff @(posedge uart_clk or negedge uart_rst_n) begin
    if (!uart_rst_n) begin
      r_state    <= RUN;
      r_divider  <= DEFAULT_DIVIDER;
      r_meas     <= '0;
      r_quiet    <= '0;
      r_cal_done <= 1'b0;
      r_cal_err  <= 1'b0;
    end else begin
      r_cal_done <= 1'b0;
      r_cal_err  <= 1'b0;
      case (r_state)
        RUN: begin
          if (cal_start) r_state <= WAIT_EDGE;
        end
        WAIT_EDGE: begin
          if (w_fall) begin
            r_meas  <= 16'd1;
            r_state <= MEASURE;
          end
        end
        MEASURE: begin
          if (w_rise) begin
            if (r_meas >= MIN_BIT) begin
              r_divider  <= r_meas - 16'd1;
              r_cal_done <= 1'b1;
              r_quiet    <= '0;
              r_state    <= QUIET;
            end else begin
              r_cal_err <= 1'b1;
              r_state   <= WAIT_EDGE;
            end
          end else if (!r_sync2) begin
            // Saturate rather than wrap: a stuck-low line is a failed measurement.
            if (r_meas == 16'hFFFF) begin
              r_cal_err <= 1'b1;
              r_state   <= WAIT_EDGE;
            end else begin
              r_meas <= r_meas + 16'd1;
            end
          end
        end
        QUIET: begin
          if (!r_sync2) begin
            r_quiet <= '0;
          end else begin
            r_quiet <= w_quiet_next;
            if (w_quiet_next >= w_quiet_target) r_state <= RUN;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  always_ff @(posedge uart_clk or negedge uart_rst_n) begin
    if (!uart_rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge uart_clk) begin
    if (w_push) r_mem[r_wr[c_AW-1:0]] <= rx_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_ctrl
// Purpose  : Scoreboard bench for uart_rx_ctrl (calibration + FIFO).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;

  localparam int DEPTH = 4;

  logic        uart_clk    = 1'b0;
  logic        uart_rst_n  = 1'b0;
  logic        uart_ser_rx = 1'b1;
  logic        cal_start   = 1'b0;
  logic [15:0] uart_divider;
  logic [7:0]  rx_data     = 8'h00;
  logic        rx_valid    = 1'b0;
  logic        rx_ready;
  logic [7:0]  fifo_data;
  logic        fifo_valid;
  logic        fifo_ready  = 1'b0;
  logic [2:0]  fifo_count;
  logic        cal_busy;
  logic        cal_done;
  logic        cal_err;

  uart_rx_ctrl #(
    .DEFAULT_DIVIDER(16'd433),
    .MIN_BIT        (16'd8),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .uart_clk    (uart_clk),
    .uart_rst_n  (uart_rst_n),
    .uart_ser_rx (uart_ser_rx),
    .cal_start   (cal_start),
    .uart_divider(uart_divider),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .fifo_data   (fifo_data),
    .fifo_valid  (fifo_valid),
    .fifo_ready  (fifo_ready),
    .fifo_count  (fifo_count),
    .cal_busy    (cal_busy),
    .cal_done    (cal_done),
    .cal_err     (cal_err)
  );

  always #5 uart_clk = ~uart_clk;

  int          total = 0;
  int          bad   = 0;
  byte unsigned exp_q[$];
  bit          model_run = 1'b1;
  int          n_acc  = 0;
  int          n_pop  = 0;
  int          n_done = 0;
  int          n_err  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, accepting only while the bench knows
  // the controller is in normal receive mode.
  always @(negedge uart_clk) begin
    int sz;
    if (!uart_rst_n) begin
      exp_q.delete();
      model_run = 1'b1;
      check("rst_divider", uart_divider, 32'd433);
      check("rst_count", fifo_count, 32'd0);
      check("rst_valid", fifo_valid, 32'd0);
      check("rst_busy", cal_busy, 32'd0);
      check("rst_done", cal_done, 32'd0);
      check("rst_err", cal_err, 32'd0);
      check("rst_rx_ready", rx_ready, 32'd1);
    end else begin
      sz = exp_q.size();
      check("fifo_count", fifo_count, sz);
      check("fifo_valid", fifo_valid, (sz > 0) ? 32'd1 : 32'd0);
      check("rx_ready", rx_ready, (!model_run || sz < DEPTH) ? 32'd1 : 32'd0);
      if (cal_done) n_done++;
      if (cal_err)  n_err++;
      if (fifo_ready && sz > 0) begin
        check("fifo_data", fifo_data, exp_q[0]);
        void'(exp_q.pop_front());
        n_pop++;
      end
      if (rx_valid && model_run && sz < DEPTH) begin
        exp_q.push_back(rx_data);
        n_acc++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge uart_clk);
    #1;
  endtask

  task automatic offer(input logic [7:0] b);
    int start;
    start    = n_acc;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 5000 && n_acc == start; i++) begin
      @(posedge uart_clk);
      #1;
    end
    check("offer_accepted", (n_acc != start) ? 32'd1 : 32'd0, 32'd1);
    rx_valid = 1'b0;
  endtask

  task automatic garbage();
    rx_data  = 8'($urandom);
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic ser_byte(input logic [7:0] b, input int bt);
    uart_ser_rx = 1'b0;
    tick(bt);
    for (int i = 0; i < 8; i++) begin
      uart_ser_rx = b[i];
      tick(bt);
    end
    uart_ser_rx = 1'b1;
    tick(bt);
  endtask

  task automatic cal_begin();
    n_done    = 0;
    n_err     = 0;
    cal_start = 1'b1;
    tick(1);
    cal_start = 1'b0;
    model_run = 1'b0;
  endtask

  // Stop bit already supplied bt high clocks; quiet window is 12*bt.
  task automatic cal_finish(input int bt);
    tick(12 * bt - bt - 10);
    check("quiet_busy", cal_busy, 32'd1);
    tick(20);
    check("quiet_run", cal_busy, 32'd0);
    model_run = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pops0;
    logic [7:0] b;
    tick(3);
    uart_rst_n = 1'b1;
    tick(2);

    // Fill with consumer stalled, then drain.
    pops0 = n_pop;
    fork
      for (int i = 0; i < 6; i++) offer(8'(8'h10 + i * 8'h11));
      begin
        tick(60);
        check("full_count", fifo_count, 32'd4);
        check("full_rx_ready", rx_ready, 32'd0);
        fifo_ready = 1'b1;
      end
    join
    tick(10);
    check("drain_pops", n_pop - pops0, 32'd6);

    // Simultaneous push/pop at three entries, then pointer wrap.
    fifo_ready = 1'b0;
    for (int i = 0; i < 3; i++) offer(8'($urandom));
    tick(2);
    rx_data    = 8'hC7;
    rx_valid   = 1'b1;
    fifo_ready = 1'b1;
    tick(1);
    rx_valid   = 1'b0;
    fifo_ready = 1'b0;
    check("pushpop_count", fifo_count, 32'd3);
    fifo_ready = 1'b1;
    for (int i = 0; i < 10; i++) offer(8'($urandom));
    tick(6);
    check("wrap_empty", fifo_count, 32'd0);

    // Calibrate at 100 clocks/bit with buffered bytes drained meanwhile.
    fifo_ready = 1'b0;
    offer(8'h11);
    offer(8'h22);
    pops0 = n_pop;
    cal_begin();
    fork
      ser_byte(8'h55, 100);
      begin
        tick(300);
        garbage();
        tick(200);
        fifo_ready = 1'b1;
      end
    join
    check("cal41_done", n_done, 32'd1);
    check("cal41_div", uart_divider, 32'd99);
    cal_finish(100);
    check("cal41_err", n_err, 32'd0);
    check("cal41_retained", n_pop - pops0, 32'd2);
    offer(8'hA3);
    tick(3);
    check("cal41_a3_pop", n_pop - pops0, 32'd3);

    // Short glitch rejected, then 50 clocks/bit.
    cal_begin();
    uart_ser_rx = 1'b0;
    tick(5);
    uart_ser_rx = 1'b1;
    tick(20);
    check("glitch_err", n_err, 32'd1);
    check("glitch_div", uart_divider, 32'd99);
    ser_byte(8'h55, 50);
    check("cal42_done", n_done, 32'd1);
    check("cal42_div", uart_divider, 32'd49);
    cal_finish(50);

    // Stuck-low line saturates the measurement.
    fifo_ready = 1'b0;
    offer(8'h5A);
    offer(8'hA5);
    cal_begin();
    uart_ser_rx = 1'b0;
    tick(70000);
    check("stuck_err", n_err, 32'd1);
    check("stuck_done", n_done, 32'd0);
    check("stuck_div", uart_divider, 32'd49);
    check("stuck_busy", cal_busy, 32'd1);
    uart_ser_rx = 1'b1;
    tick(10);
    uart_ser_rx = 1'b0;
    tick(3);
    uart_ser_rx = 1'b1;
    tick(10);
    check("stuck_wait_edge", n_err, 32'd2);

    // Reset in the middle of a measurement.
    uart_ser_rx = 1'b0;
    tick(20);
    uart_rst_n  = 1'b0;
    tick(3);
    uart_ser_rx = 1'b1;
    uart_rst_n  = 1'b1;
    tick(2);
    check("rst45_div", uart_divider, 32'd433);
    check("rst45_busy", cal_busy, 32'd0);
    check("rst45_count", fifo_count, 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      b          = 8'($urandom);
      rx_data    = b;
      rx_valid   = ($urandom_range(0, 3) != 0);
      fifo_ready = ($urandom_range(0, 2) != 0);
      tick(1);
    end
    rx_valid   = 1'b0;
    fifo_ready = 1'b1;
    tick(8);
    check("final_empty", fifo_count, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
